// File: rtl/diff_seq_pkg.sv
// Shared types and constants for the differential-equivalence sequencer:
// FSM encoding, stimulus/result widths and the wire field layout in the stimulus word.
package diff_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int STIM_W = 68;
    localparam int Y_W    = 117;

    localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

    // Field layout of {wire3, wire2, wire1, wire0} inside the 68-bit stimulus word.
    localparam int W0_OFF = 0;
    localparam int W0_W   = 21;
    localparam int W1_OFF = 21;
    localparam int W1_W   = 8;
    localparam int W2_OFF = 29;
    localparam int W2_W   = 18;
    localparam int W3_OFF = 47;
    localparam int W3_W   = 21;

    localparam int DRIVE_STEPS = 3;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] poly);
        return (s >> 1) ^ (s[0] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/diff_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
// A zero load value is replaced by 1 so the register never locks up.
module diff_lfsr32
    import diff_seq_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] state,
    output logic [31:0] next_state
);

    logic [31:0] lfsr_q;

    assign state      = lfsr_q;
    assign next_state = lfsr_next(lfsr_q, POLY);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 32'h1;
        end else if (load) begin
            lfsr_q <= (load_value == 32'h0) ? 32'h1 : load_value;
        end else if (step) begin
            lfsr_q <= next_state;
        end
    end

endmodule

// File: rtl/diff_vector_sequencer.sv
// Drives LFSR stimulus into a reference/synthesized datapath pair, waits for the
// outputs to settle, then compares them under a mask and accumulates statistics.
module diff_vector_sequencer
    import diff_seq_pkg::*;
#(
    parameter int             SETTLE_CYCLES = 4,
    parameter logic [Y_W-1:0] CMP_MASK      = 117'h1F_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE,
    parameter logic [31:0]    POLY          = DEFAULT_POLY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         num_vectors,
    input  logic [31:0]         seed,
    input  logic                stop_on_mismatch,
    output logic [W0_W-1:0]     stim_wire0,
    output logic [W1_W-1:0]     stim_wire1,
    output logic [W2_W-1:0]     stim_wire2,
    output logic [W3_W-1:0]     stim_wire3,
    input  logic [Y_W-1:0]      y_ref,
    input  logic [Y_W-1:0]      y_dut,
    output logic                busy,
    output logic                done,
    output logic [15:0]         vec_count,
    output logic [15:0]         mismatch_count,
    output logic                fail_valid,
    output logic [15:0]         first_fail_idx,
    output logic [Y_W-1:0]      first_fail_diff
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [1:0]  DRIVE_LAST  = 2'(DRIVE_STEPS - 1);

    state_t state, state_n;

    logic [1:0]        drive_cnt;
    logic [15:0]       settle_cnt;
    logic [31:0]       s0_q;
    logic [STIM_W-1:0] stim_q;
    logic [STIM_W-1:0] stim_word;
    logic [Y_W-1:0]    cap_ref;
    logic [Y_W-1:0]    cap_dut;
    logic [Y_W-1:0]    diff;
    logic              diff_nz;
    logic              last_vec;
    logic [15:0]       cfg_num;
    logic              cfg_stop;
    logic              accept;
    logic              lfsr_load;
    logic              lfsr_step;
    logic [31:0]       lfsr_state;
    logic [31:0]       lfsr_next_state;

    diff_lfsr32 #(.POLY(POLY)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .load_value (seed),
        .step       (lfsr_step),
        .state      (lfsr_state),
        .next_state (lfsr_next_state)
    );

    // On the third DRIVE cycle lfsr_state holds s1 and lfsr_next_state is s2.
    assign stim_word = {lfsr_next_state[3:0], lfsr_state, s0_q};

    assign diff     = (cap_ref ^ cap_dut) & CMP_MASK;
    assign diff_nz  = |diff;
    assign last_vec = ({1'b0, vec_count} + 17'd1) == {1'b0, cfg_num};

    // start is a single-cycle request; it is accepted only in IDLE or DONE and
    // dropped silently otherwise, so there is no ready/ack path back to the host.
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        state_n   = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    state_n   = (num_vectors == 16'd0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                lfsr_step = 1'b1;
                if (drive_cnt == DRIVE_LAST) begin
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_n = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (last_vec || (diff_nz && cfg_stop)) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_DRIVE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            drive_cnt       <= 2'd0;
            settle_cnt      <= 16'd0;
            s0_q            <= 32'h0;
            stim_q          <= '0;
            cap_ref         <= '0;
            cap_dut         <= '0;
            cfg_num         <= 16'd0;
            cfg_stop        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            vec_count       <= 16'd0;
            mismatch_count  <= 16'd0;
            fail_valid      <= 1'b0;
            first_fail_idx  <= 16'd0;
            first_fail_diff <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cfg_num         <= num_vectors;
                cfg_stop        <= stop_on_mismatch;
                drive_cnt       <= 2'd0;
                settle_cnt      <= 16'd0;
                vec_count       <= 16'd0;
                mismatch_count  <= 16'd0;
                fail_valid      <= 1'b0;
                first_fail_idx  <= 16'd0;
                first_fail_diff <= '0;
                busy            <= (num_vectors != 16'd0);
                done            <= (num_vectors == 16'd0);
            end
            case (state)
                ST_DRIVE: begin
                    if (drive_cnt == 2'd0) begin
                        drive_cnt <= 2'd1;
                    end else if (drive_cnt == 2'd1) begin
                        s0_q      <= lfsr_state;
                        drive_cnt <= 2'd2;
                    end else begin
                        stim_q     <= stim_word;
                        drive_cnt  <= 2'd0;
                        settle_cnt <= 16'd0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 16'd1;
                end
                ST_SAMPLE: begin
                    cap_ref <= y_ref;
                    cap_dut <= y_dut;
                end
                ST_COMPARE: begin
                    vec_count <= vec_count + 16'd1;
                    if (diff_nz) begin
                        mismatch_count <= mismatch_count + 16'd1;
                        if (!fail_valid) begin
                            fail_valid      <= 1'b1;
                            first_fail_idx  <= vec_count;
                            first_fail_diff <= diff;
                        end
                    end
                    if (state_n == ST_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stim_wire0 = stim_q[W0_OFF +: W0_W];
    assign stim_wire1 = stim_q[W1_OFF +: W1_W];
    assign stim_wire2 = stim_q[W2_OFF +: W2_W];
    assign stim_wire3 = stim_q[W3_OFF +: W3_W];

endmodule

// File: tb/tb_diff_vector_sequencer.sv
// Directed bench for diff_vector_sequencer: a stand-in datapath pair with
// controllable fault injection, hand-computed expected values and a summary line.
module tb_diff_vector_sequencer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [15:0]  num_vectors;
    logic [31:0]  seed;
    logic         stop_on_mismatch;
    logic [20:0]  stim_wire0;
    logic [7:0]   stim_wire1;
    logic [17:0]  stim_wire2;
    logic [20:0]  stim_wire3;
    logic [116:0] y_ref;
    logic [116:0] y_dut;
    logic         busy;
    logic         done;
    logic [15:0]  vec_count;
    logic [15:0]  mismatch_count;
    logic         fail_valid;
    logic [15:0]  first_fail_idx;
    logic [116:0] first_fail_diff;

    int n_checks;
    int n_fails;
    int tick;
    int t0;
    bit bit0_toggle;
    bit fault_on;
    int fault_vec;
    int lat;
    int busy_cnt;

    diff_vector_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_vectors      (num_vectors),
        .seed             (seed),
        .stop_on_mismatch (stop_on_mismatch),
        .stim_wire0       (stim_wire0),
        .stim_wire1       (stim_wire1),
        .stim_wire2       (stim_wire2),
        .stim_wire3       (stim_wire3),
        .y_ref            (y_ref),
        .y_dut            (y_dut),
        .busy             (busy),
        .done             (done),
        .vec_count        (vec_count),
        .mismatch_count   (mismatch_count),
        .fail_valid       (fail_valid),
        .first_fail_idx   (first_fail_idx),
        .first_fail_diff  (first_fail_diff)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // Stand-in datapath pair; vector k is sampled while (tick - t0) / 9 == k.
    logic [67:0] stim_cat;
    always_comb begin
        stim_cat = {stim_wire3, stim_wire2, stim_wire1, stim_wire0};
        y_ref    = {stim_cat[48:0], stim_cat};
        y_dut    = y_ref;
        if (bit0_toggle) y_dut[0] = y_ref[0] ^ tick[0];
        if (fault_on && ((tick - t0) / 9 == fault_vec)) y_dut[5] = ~y_ref[5];
    end

    task automatic check(input string tag, input logic [116:0] obs, input logic [116:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] s, input logic [15:0] nv, input logic stop);
        seed             = s;
        num_vectors      = nv;
        stop_on_mismatch = stop;
        start            = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = tick;
    endtask

    // Latency counts the accepting edge as 1; busy_cnt counts cycles with busy high.
    task automatic wait_done(input int limit, output int latency, output int nbusy);
        latency = 1;
        nbusy   = busy ? 1 : 0;
        while (!done && latency < limit) begin
            @(posedge clk);
            #1;
            latency++;
            if (busy) nbusy++;
        end
        check("done_within_budget", 117'(done), 117'd1);
    endtask

    initial begin
        n_checks = 0; n_fails = 0; tick = 0; t0 = 0;
        bit0_toggle = 0; fault_on = 0; fault_vec = 0;
        start = 0; num_vectors = 0; seed = 0; stop_on_mismatch = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stim0", 117'(stim_wire0), 117'd0);
        check("rst_stim3", 117'(stim_wire3), 117'd0);
        check("rst_busy", 117'(busy), 117'd0);
        check("rst_done", 117'(done), 117'd0);
        check("rst_vec_count", 117'(vec_count), 117'd0);
        check("rst_fail_diff", first_fail_diff, 117'd0);
        rst = 0;
        @(posedge clk); #1;

        // one vector, seed 1
        start_run(32'h1, 16'd1, 1'b0);
        check("t1_busy_after_start", 117'(busy), 117'd1);
        wait_done(50, lat, busy_cnt);
        check("t1_latency", 117'(lat), 117'd10);
        check("t1_stim0", 117'(stim_wire0), 117'h000003);
        check("t1_stim1", 117'(stim_wire1), 117'h01);
        check("t1_stim2", 117'(stim_wire2), 117'h00014);
        check("t1_stim3", 117'(stim_wire3), 117'h38060);
        check("t1_vec_count", 117'(vec_count), 117'd1);
        check("t1_mismatch", 117'(mismatch_count), 117'd0);
        check("t1_busy_low", 117'(busy), 117'd0);

        // zero vectors from DONE: counters cleared, stimulus untouched
        start_run(32'h1234, 16'd0, 1'b0);
        check("t0v_done", 117'(done), 117'd1);
        check("t0v_busy", 117'(busy), 117'd0);
        check("t0v_vec_count", 117'(vec_count), 117'd0);
        check("t0v_mismatch", 117'(mismatch_count), 117'd0);
        check("t0v_stim0_kept", 117'(stim_wire0), 117'h000003);

        // 100 vectors, only the masked bit 0 differs
        bit0_toggle = 1;
        start_run(32'hACE1_1234, 16'd100, 1'b0);
        check("t100_done_dropped", 117'(done), 117'd0);
        wait_done(2000, lat, busy_cnt);
        check("t100_vec_count", 117'(vec_count), 117'd100);
        check("t100_mismatch", 117'(mismatch_count), 117'd0);
        check("t100_fail_valid", 117'(fail_valid), 117'd0);
        check("t100_busy_cycles", 117'(busy_cnt), 117'd900);
        bit0_toggle = 0;

        // bit 5 fault on vector 7, run continues
        fault_on = 1; fault_vec = 7;
        start_run(32'h1, 16'd20, 1'b0);
        wait_done(400, lat, busy_cnt);
        check("tf_vec_count", 117'(vec_count), 117'd20);
        check("tf_mismatch", 117'(mismatch_count), 117'd1);
        check("tf_fail_valid", 117'(fail_valid), 117'd1);
        check("tf_first_idx", 117'(first_fail_idx), 117'd7);
        check("tf_first_diff", first_fail_diff, 117'h20);

        // same fault, stop at first mismatch
        start_run(32'h1, 16'd20, 1'b1);
        wait_done(400, lat, busy_cnt);
        check("ts_vec_count", 117'(vec_count), 117'd8);
        check("ts_mismatch", 117'(mismatch_count), 117'd1);
        check("ts_first_idx", 117'(first_fail_idx), 117'd7);
        check("ts_busy_cycles", 117'(busy_cnt), 117'd72);
        fault_on = 0;

        // start while busy is ignored
        start_run(32'h5555_AAAA, 16'd5, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1; num_vectors = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("tig_still_busy", 117'(busy), 117'd1);
        wait_done(200, lat, busy_cnt);
        check("tig_vec_count", 117'(vec_count), 117'd5);

        // reset during SETTLE of vector 3
        start_run(32'h1, 16'd10, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        check("tr_busy_before", 117'(busy), 117'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("tr_stim0", 117'(stim_wire0), 117'd0);
        check("tr_stim2", 117'(stim_wire2), 117'd0);
        check("tr_busy", 117'(busy), 117'd0);
        check("tr_done", 117'(done), 117'd0);
        check("tr_vec_count", 117'(vec_count), 117'd0);
        check("tr_mismatch", 117'(mismatch_count), 117'd0);
        check("tr_fail_valid", 117'(fail_valid), 117'd0);
        check("tr_first_idx", 117'(first_fail_idx), 117'd0);
        start_run(32'h1, 16'd1, 1'b0);
        wait_done(50, lat, busy_cnt);
        check("tr_rerun_stim0", 117'(stim_wire0), 117'h000003);
        check("tr_rerun_stim1", 117'(stim_wire1), 117'h01);
        check("tr_rerun_stim2", 117'(stim_wire2), 117'h00014);
        check("tr_rerun_stim3", 117'(stim_wire3), 117'h38060);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/diff_vector_sequencer.md
# diff_vector_sequencer

Sequencer for differential equivalence runs on a combinational fuzz datapath: two implementations of the same 4-input / 117-bit-output block, a reference build and a synthesized build. It generates pseudo-random stimulus from an LFSR and drives all four datapath inputs in lockstep. It waits a programmable settle window so the datapath's assign delays resolve, then samples both outputs, compares them under a mask and accumulates pass/fail statistics. It sits between the bench/host control registers and the pair of datapath instances.

## Interface
- SETTLE_CYCLES, 4, cycles between stimulus update and output sample (≥1)
- CMP_MASK, 117'h1F_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, per-bit compare enable (bit 0 is constant 0 in the datapath, so it is masked)
- POLY, 32'h8020_0003, Galois LFSR feedback polynomial
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  launch a run; sampled only in IDLE or DONE
- num_vectors  input  16  vectors to apply; captured at start
- seed  input  32  LFSR seed; captured at start; 0 replaced by 32'h1
- stop_on_mismatch  input  1  end run at first failing vector; captured at start
- stim_wire0  output  21  drives datapath wire0 (both instances)
- stim_wire1  output  8  drives wire1
- stim_wire2  output  18  drives wire2
- stim_wire3  output  21  drives wire3
- y_ref  input  117  reference instance output
- y_dut  input  117  synthesized instance output
- busy  output  1  run in progress
- done  output  1  run finished; held until next start or reset
- vec_count  output  16  vectors compared so far
- mismatch_count  output  16  failing vectors so far
- fail_valid  output  1  at least one mismatch recorded this run
- first_fail_idx  output  16  0-based index of first failing vector
- first_fail_diff  output  117  (y_ref ^ y_dut) & CMP_MASK of first failing vector

## Operation
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, COMPARE, DONE.
- IDLE/DONE + start: capture configuration, load LFSR with seed, clear counters, fail_valid, first_fail_idx and first_fail_diff, set settle counter to 0. Go to DRIVE, or to DONE if num_vectors = 0.
- DRIVE: 3 cycles. Each cycle performs one LFSR step: next = (s >> 1) ^ (s[0] ? POLY : 0). States after steps 1..3 are s0, s1, s2. On the third cycle's edge, load the concatenation {stim_wire3, stim_wire2, stim_wire1, stim_wire0} with bits [67:0] of {s2, s1, s0}. All four outputs update on the same edge. Then go to SETTLE.
- SETTLE: hold stimulus for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: register y_ref and y_dut into internal capture registers.
- COMPARE: diff = (cap_ref ^ cap_dut) & CMP_MASK; vec_count += 1. If diff ≠ 0: mismatch_count += 1, and if fail_valid = 0, set fail_valid and latch first_fail_idx = vec_count (pre-increment) and first_fail_diff = diff. Next state:
  - DONE if vec_count+1 = num_vectors, or if (diff ≠ 0 and stop_on_mismatch);
  - otherwise DRIVE.
- The LFSR advances only in DRIVE, so a given seed yields a deterministic vector sequence.
- Counters cannot overflow: vec_count ≤ num_vectors ≤ 65535.
- start while busy is ignored.

## Timing
- Reset values: all stim_* = 0, busy = 0, done = 0, vec_count = 0, mismatch_count = 0, fail_valid = 0, first_fail_idx = 0, first_fail_diff = 0, FSM = IDLE, LFSR = 32'h1.
- busy rises the cycle after start is accepted and falls on entry to DONE. done rises on that same edge.
- Per vector: 3 + SETTLE_CYCLES + 2 cycles. The default is 9.
- Status outputs update on the COMPARE edge; they are registered, with no combinational path from y_*.
- num_vectors = 0: done one cycle after start; counters stay 0; stimulus unchanged.
- Reset mid-run: return to reset values on the next edge; no partial statistics are retained.
- start in DONE: done drops and busy rises on the same edge.

## Structure
- Shared package diff_seq_pkg: state enum, STIM_W = 68, Y_W = 117, default POLY, field offsets for wire0..wire3 within the stimulus word.
- One natural sub-module: diff_lfsr32 (load, step, state out).
- Compare/statistics logic stays inline.

## Test plan
- Seed 32'h1, num_vectors = 1, y_ref = y_dut → stim_wire0 = 21'h000003, stim_wire1 = 8'h01, stim_wire2 = 18'h00014, stim_wire3 = 21'h38060; done 10 cycles after start; vec_count = 1, mismatch_count = 0.
- num_vectors = 100, outputs forced equal except bit 0 toggling → mismatch_count = 0 (masked), vec_count = 100, busy high for exactly 900 cycles.
- Force y_dut bit 5 flipped on vector 7 only, stop_on_mismatch = 0, num_vectors = 20 → mismatch_count = 1, first_fail_idx = 7, first_fail_diff = 117'h20, vec_count = 20.
- Same as above with stop_on_mismatch = 1 → done after vector 7; vec_count = 8.
- num_vectors = 0 → done one cycle after start, all counters 0. A second start pulse while busy during a 5-vector run → ignored, vec_count = 5.
- Assert rst during SETTLE of vector 3 → next cycle all outputs at reset values. A subsequent start with the same seed reproduces the vector-0 stimulus above.
